rv_encoder_pipe: RTL and testbench

- Streaming RV32I instruction encoder for the assembler datapath.
- Accepts decoded instruction fields (opcode, funct3, funct7, rd, rs1, rs2, imm) over a valid/ready handshake.
- Validates the fields, packs them into a 32-bit machine word per format (R/I/S/B/U/J), and buffers results in a parametrised output FIFO.
- Sits between the INSTRUCTION_MAPPING stage of the assembler FSM and instruction-memory write-back; reports per-word error codes and can optionally halt on first error.

---
 rtl/rv_encoder_pipe.sv | 228 ++++++++++++++++++++++
 tb/tb_rv_encoder_pipe.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_encoder_pipe.sv
// RV32I instruction encoder: registers decoded fields, validates and packs
// them into a machine word, and buffers words with error codes in a FIFO.
module rv_encoder_pipe #(
  parameter int FIFO_DEPTH = 4,
  parameter bit STICKY_ERR = 1'b1,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             in_valid_in,
  output logic             in_ready_out,
  input  logic [6:0]       opcode_in,
  input  logic [2:0]       funct3_in,
  input  logic [6:0]       funct7_in,
  input  logic [4:0]       rd_in,
  input  logic [4:0]       rs1_in,
  input  logic [4:0]       rs2_in,
  input  logic [31:0]      imm_in,
  output logic             out_valid_out,
  input  logic             out_ready_in,
  output logic [31:0]      word_out,
  output logic             err_out,
  output logic [2:0]       err_code_out,
  output logic             halted_out,
  input  logic             err_clr_in,
  output logic [CNT_W-1:0] fifo_count_out
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_OPCODE = 3'd1;
  localparam logic [2:0] ERR_RANGE  = 3'd2;
  localparam logic [2:0] ERR_ALIGN  = 3'd3;
  localparam logic [2:0] ERR_FUNCT  = 3'd4;

  // Stage-1 field registers
  logic               s1_valid_q;
  logic [6:0]         s1_op_q;
  logic [2:0]         s1_f3_q;
  logic [6:0]         s1_f7_q;
  logic [4:0]         s1_rd_q;
  logic [4:0]         s1_rs1_q;
  logic [4:0]         s1_rs2_q;
  logic signed [31:0] s1_imm_q;

  // Encoder results
  logic [31:0] enc_word;
  logic [2:0]  enc_code;

  // FIFO state
  logic [31:0]      mem_word_q [FIFO_DEPTH];
  logic [2:0]       mem_code_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             halted_q, halted_d;

  logic             accept;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] occupancy;

  function automatic logic out_rng(input logic signed [31:0] v,
                                   input logic signed [31:0] lo,
                                   input logic signed [31:0] hi);
    return (v < lo) || (v > hi);
  endfunction

  // Stage 1 counts toward occupancy so an accepted word always has a FIFO slot.
  assign occupancy    = count_q + CNT_W'(s1_valid_q);
  assign in_ready_out = rst_n_in & ~halted_q & (occupancy < CNT_W'(FIFO_DEPTH));
  assign accept       = in_valid_in & in_ready_out;
  assign push         = s1_valid_q;
  assign pop          = out_ready_in & (count_q != '0);

  // Capture fields on handshake; the stage drains into the FIFO every cycle.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_f3_q    <= '0;
      s1_f7_q    <= '0;
      s1_rd_q    <= '0;
      s1_rs1_q   <= '0;
      s1_rs2_q   <= '0;
      s1_imm_q   <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_op_q  <= opcode_in;
        s1_f3_q  <= funct3_in;
        s1_f7_q  <= funct7_in;
        s1_rd_q  <= rd_in;
        s1_rs1_q <= rs1_in;
        s1_rs2_q <= rs2_in;
        s1_imm_q <= imm_in;
      end
    end
  end

  // Validate and pack; checks are ordered opcode, funct, alignment, range.
  always_comb begin
    enc_code = ERR_NONE;
    enc_word = '0;
    case (s1_op_q)
      OP_REG: begin
        if (!(s1_f7_q == 7'b0000000 ||
              (s1_f7_q == 7'b0100000 && (s1_f3_q == 3'b000 || s1_f3_q == 3'b101))))
          enc_code = ERR_FUNCT;
        enc_word = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      end
      OP_IMM: begin
        if (s1_f3_q == 3'b001 || s1_f3_q == 3'b101) begin
          if (!(s1_f7_q == 7'b0000000 || (s1_f7_q == 7'b0100000 && s1_f3_q == 3'b101)))
            enc_code = ERR_FUNCT;
          else if (out_rng(s1_imm_q, 32'sd0, 32'sd31))
            enc_code = ERR_RANGE;
          enc_word = {s1_f7_q, s1_imm_q[4:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
        end else begin
          if (out_rng(s1_imm_q, -32'sd2048, 32'sd2047)) enc_code = ERR_RANGE;
          enc_word = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
        end
      end
      OP_LOAD: begin
        if (s1_f3_q == 3'b011 || s1_f3_q == 3'b110 || s1_f3_q == 3'b111)
          enc_code = ERR_FUNCT;
        else if (out_rng(s1_imm_q, -32'sd2048, 32'sd2047))
          enc_code = ERR_RANGE;
        enc_word = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      end
      OP_JALR: begin
        if (s1_f3_q != 3'b000)
          enc_code = ERR_FUNCT;
        else if (out_rng(s1_imm_q, -32'sd2048, 32'sd2047))
          enc_code = ERR_RANGE;
        enc_word = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q};
      end
      OP_STORE: begin
        if (s1_f3_q[2] || s1_f3_q == 3'b011)
          enc_code = ERR_FUNCT;
        else if (out_rng(s1_imm_q, -32'sd2048, 32'sd2047))
          enc_code = ERR_RANGE;
        enc_word = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q, s1_imm_q[4:0], s1_op_q};
      end
      OP_BRANCH: begin
        if (s1_f3_q == 3'b010 || s1_f3_q == 3'b011)
          enc_code = ERR_FUNCT;
        else if (s1_imm_q[0])
          enc_code = ERR_ALIGN;
        else if (out_rng(s1_imm_q, -32'sd4096, 32'sd4094))
          enc_code = ERR_RANGE;
        enc_word = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                    s1_imm_q[4:1], s1_imm_q[11], s1_op_q};
      end
      OP_JAL: begin
        if (s1_imm_q[0])
          enc_code = ERR_ALIGN;
        else if (out_rng(s1_imm_q, -32'sd1048576, 32'sd1048574))
          enc_code = ERR_RANGE;
        enc_word = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                    s1_rd_q, s1_op_q};
      end
      OP_LUI, OP_AUIPC: begin
        if (out_rng(s1_imm_q, 32'sd0, 32'sd1048575)) enc_code = ERR_RANGE;
        enc_word = {s1_imm_q[19:0], s1_rd_q, s1_op_q};
      end
      default: enc_code = ERR_OPCODE;
    endcase
    if (enc_code != ERR_NONE) enc_word = '0;
  end

  // FIFO pointer/count and halt next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    halted_d = halted_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
    if (err_clr_in) halted_d = 1'b0;
    // An errored push wins over a coincident clear.
    if (STICKY_ERR && push && enc_code != ERR_NONE) halted_d = 1'b1;
  end

  // Control state registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      halted_q <= halted_d;
    end
  end

  // FIFO storage; contents are only observable while count is nonzero.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_word_q[wr_ptr_q] <= enc_word;
      mem_code_q[wr_ptr_q] <= enc_code;
    end
  end

  assign out_valid_out  = (count_q != '0);
  assign word_out       = out_valid_out ? mem_word_q[rd_ptr_q] : 32'd0;
  assign err_code_out   = out_valid_out ? mem_code_q[rd_ptr_q] : ERR_NONE;
  assign err_out        = (err_code_out != ERR_NONE);
  assign halted_out     = halted_q;
  assign fifo_count_out = count_q;

endmodule

// File: tb/tb_rv_encoder_pipe.sv
// Bench for rv_encoder_pipe: directed cases plus randomized fields checked
// against a field-rule reference model and an in-order expected-word queue.
module tb_rv_encoder_pipe;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk_in, rst_n_in;
  logic          in_valid_in, in_ready_out;
  logic [6:0]    opcode_in, funct7_in;
  logic [2:0]    funct3_in;
  logic [4:0]    rd_in, rs1_in, rs2_in;
  logic [31:0]   imm_in;
  logic          out_valid_out, out_ready_in;
  logic [31:0]   word_out;
  logic          err_out;
  logic [2:0]    err_code_out;
  logic          halted_out, err_clr_in;
  logic [CW-1:0] fifo_count_out;

  int          n_vec, n_err;
  logic [35:0] exp_q[$];
  logic [35:0] mon_e;
  bit          rand_ready;
  logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
  int          bnd [16] = '{-4097, -4096, -2049, -2048, -1, 0, 1, 31, 32, 2047, 2048,
                            4094, 4095, 1048575, 1048576, -1048577};

  rv_encoder_pipe #(.FIFO_DEPTH(DEPTH), .STICKY_ERR(1'b1)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .in_valid_in(in_valid_in), .in_ready_out(in_ready_out),
    .opcode_in(opcode_in), .funct3_in(funct3_in), .funct7_in(funct7_in),
    .rd_in(rd_in), .rs1_in(rs1_in), .rs2_in(rs2_in), .imm_in(imm_in),
    .out_valid_out(out_valid_out), .out_ready_in(out_ready_in),
    .word_out(word_out), .err_out(err_out), .err_code_out(err_code_out),
    .halted_out(halted_out), .err_clr_in(err_clr_in),
    .fifo_count_out(fifo_count_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: {code, err, word} from the instruction-format rules.
  function automatic logic [35:0] model(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input int imm);
    bit known = 1, f_ok = 1, even_req = 0, has_rng = 0;
    longint lo = 0, hi = 0;
    logic [31:0] u = imm, w = 0, rdv, r1, r2, f3v, opv;
    logic [2:0] c;
    rdv = 32'(rd) << 7;  r1 = 32'(rs1) << 15;  r2 = 32'(rs2) << 20;
    f3v = 32'(f3) << 12; opv = 32'(op);
    case (op)
      7'h33: begin
        f_ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        w = (32'(f7) << 25) | r2 | r1 | f3v | rdv | opv;
      end
      7'h13: begin
        has_rng = 1;
        if (f3 == 1 || f3 == 5) begin
          f_ok = (f7 == 0) || (f7 == 7'h20 && f3 == 5);
          lo = 0; hi = 31;
          w = (32'(f7) << 25) | ((u & 31) << 20) | r1 | f3v | rdv | opv;
        end else begin
          lo = -2048; hi = 2047;
          w = ((u & 32'hFFF) << 20) | r1 | f3v | rdv | opv;
        end
      end
      7'h03, 7'h67: begin
        f_ok = (op == 7'h67) ? (f3 == 0) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        has_rng = 1; lo = -2048; hi = 2047;
        w = ((u & 32'hFFF) << 20) | r1 | f3v | rdv | opv;
      end
      7'h23: begin
        f_ok = (f3 <= 2); has_rng = 1; lo = -2048; hi = 2047;
        w = (((u >> 5) & 127) << 25) | r2 | r1 | f3v | ((u & 31) << 7) | opv;
      end
      7'h63: begin
        f_ok = !(f3 == 2 || f3 == 3); even_req = 1; has_rng = 1; lo = -4096; hi = 4094;
        w = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | r2 | r1 | f3v |
            (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | opv;
      end
      7'h6F: begin
        even_req = 1; has_rng = 1; lo = -1048576; hi = 1048574;
        w = (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21) | (((u >> 11) & 1) << 20) |
            (((u >> 12) & 255) << 12) | rdv | opv;
      end
      7'h37, 7'h17: begin
        has_rng = 1; lo = 0; hi = 1048575;
        w = ((u & 32'hFFFFF) << 12) | rdv | opv;
      end
      default: known = 0;
    endcase
    if (!known)                                                   c = 1;
    else if (!f_ok)                                               c = 4;
    else if (even_req && u[0])                                    c = 3;
    else if (has_rng && (longint'(imm) < lo || longint'(imm) > hi)) c = 2;
    else                                                          c = 0;
    if (c != 0) w = 0;
    return {c, (c != 0), w};
  endfunction

  // Scoreboard: every word the consumer takes must be the next expected one.
  always @(negedge clk_in) begin
    if (rst_n_in === 1'b1 && out_valid_out === 1'b1 && out_ready_in === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $error("FAIL extra_word: observed %h expected no word", word_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_word", 64'({err_code_out, err_out, word_out}), 64'(mon_e));
      end
    end
  end

  task automatic step();
    @(posedge clk_in); #1;
  endtask

  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input int imm, input logic [35:0] expv);
    bit acc = 0;
    opcode_in = op; funct3_in = f3; funct7_in = f7;
    rd_in = rd; rs1_in = rs1; rs2_in = rs2; imm_in = imm;
    in_valid_in = 1'b1;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk_in);
      if (in_ready_out === 1'b1) begin
        acc = 1;
        exp_q.push_back(expv);
      end
      @(posedge clk_in); #1;
      if (rand_ready) out_ready_in = ($urandom_range(0, 3) != 0);
    end
    in_valid_in = 1'b0;
    if (!acc) begin
      n_vec++; n_err++;
      $error("FAIL send_timeout: in_ready_out observed %b required 1", in_ready_out);
    end
  endtask

  task automatic send_m(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input int imm);
    send(op, f3, f7, rd, rs1, rs2, imm, model(op, f3, f7, rd, rs1, rs2, imm));
  endtask

  task automatic drain();
    out_ready_in = 1'b1;
    for (int t = 0; t < 300 && exp_q.size() != 0; t++) step();
    step();
    check("drain_left", exp_q.size(), 0);
    check("drain_count", fifo_count_out, 0);
  endtask

  // Errored word halts input; a clear coincident with the errored push loses.
  task automatic err_case(input string tag, input logic [6:0] op, input logic [2:0] f3,
                          input int imm, input logic [2:0] code);
    out_ready_in = 1'b1;
    send(op, f3, 7'd0, 5'd1, 5'd1, 5'd2, imm, {code, 1'b1, 32'd0});
    err_clr_in = 1'b1;
    step();
    err_clr_in = 1'b0;
    @(negedge clk_in);
    check({tag, "_halt"}, halted_out, 1);
    check({tag, "_ready_lo"}, in_ready_out, 0);
    step();
    err_clr_in = 1'b1;
    step();
    err_clr_in = 1'b0;
    @(negedge clk_in);
    check({tag, "_halt_clr"}, halted_out, 0);
    check({tag, "_ready_hi"}, in_ready_out, 1);
    step();
  endtask

  task automatic send_rand(output logic [2:0] code);
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [4:0] rd, rs1, rs2;
    int imm, k;
    logic [35:0] e;
    k = $urandom_range(0, 9);
    op = (k == 9) ? 7'($urandom) : ops[k];
    f3 = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 2))
      0:       f7 = 7'h00;
      1:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    case ($urandom_range(0, 3))
      0:       imm = int'($urandom_range(0, 4095)) - 2048;
      1:       imm = bnd[$urandom_range(0, 15)];
      2:       imm = int'($urandom_range(0, 2097151)) - 1048576;
      default: imm = int'($urandom);
    endcase
    e = model(op, f3, f7, rd, rs1, rs2, imm);
    code = e[35:33];
    send(op, f3, f7, rd, rs1, rs2, imm, e);
  endtask

  initial begin
    logic [2:0] rc;
    n_vec = 0; n_err = 0; rand_ready = 0;
    rst_n_in = 1'b1; in_valid_in = 1'b0; out_ready_in = 1'b0; err_clr_in = 1'b0;
    opcode_in = '0; funct3_in = '0; funct7_in = '0;
    rd_in = '0; rs1_in = '0; rs2_in = '0; imm_in = '0;
    #2 rst_n_in = 1'b0;
    #10;
    check("rst_ready", in_ready_out, 0);
    check("rst_valid", out_valid_out, 0);
    check("rst_word", word_out, 0);
    check("rst_err", {err_code_out, err_out}, 0);
    check("rst_count", fifo_count_out, 0);
    check("rst_halt", halted_out, 0);
    @(negedge clk_in) rst_n_in = 1'b1;
    step();

    // addi x1,x0,5 latency
    send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 5, {4'b0000, 32'h00500093});
    @(negedge clk_in);
    check("addi_early", out_valid_out, 0);
    step();
    @(negedge clk_in);
    check("addi_valid", out_valid_out, 1);
    check("addi_word", word_out, 32'h00500093);
    check("addi_err", err_out, 0);
    step();
    drain();

    // add / sub / srai back to back
    out_ready_in = 1'b1;
    send(7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 0, {4'b0000, 32'h002081B3});
    send(7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 0, {4'b0000, 32'h402081B3});
    send(7'h13, 3'd5, 7'h20, 5'd1, 5'd1, 5'd0, 3, {4'b0000, 32'h4030D093});
    drain();

    // beq / jal / lui
    send(7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 8, {4'b0000, 32'h00208463});
    send(7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 2048, {4'b0000, 32'h001000EF});
    send(7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345, {4'b0000, 32'h123452B7});
    drain();

    err_case("e_range", 7'h13, 3'd0, 2048, 3'd2);
    err_case("e_align", 7'h63, 3'd0, 3, 3'd3);
    err_case("e_opc", 7'h00, 3'd0, 0, 3'd1);
    err_case("e_funct", 7'h23, 3'd4, 0, 3'd4);
    drain();

    // Backpressure: DEPTH words fit, the next one waits
    out_ready_in = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      send_m(7'h13, 3'd0, 7'd0, 5'(i + 1), 5'(i), 5'd0, int'($urandom_range(0, 4095)) - 2048);
    check("bp_ready_lo", in_ready_out, 0);
    step();
    @(negedge clk_in);
    check("bp_count", fifo_count_out, DEPTH);
    check("bp_ready_hold", in_ready_out, 0);
    step();
    out_ready_in = 1'b1;
    send_m(7'h33, 3'd0, 7'h20, 5'd7, 5'd8, 5'd9, 0);
    drain();

    // Asynchronous reset with FIFO half full
    out_ready_in = 1'b0;
    send_m(7'h37, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'hABCDE);
    send_m(7'h03, 3'd2, 7'd0, 5'd4, 5'd3, 5'd0, -4);
    step();
    step();
    #2 rst_n_in = 1'b0;
    #1;
    check("arst_valid", out_valid_out, 0);
    check("arst_word", word_out, 0);
    check("arst_err", {err_code_out, err_out}, 0);
    check("arst_count", fifo_count_out, 0);
    check("arst_ready", in_ready_out, 0);
    exp_q.delete();
    @(negedge clk_in) rst_n_in = 1'b1;
    step();
    check("arst_post_count", fifo_count_out, 0);
    out_ready_in = 1'b1;
    send(7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 5, {4'b0000, 32'h00500093});
    drain();

    // Randomized fields against the reference model
    rand_ready = 1;
    repeat (200) begin
      send_rand(rc);
      if (rc != 3'd0) begin
        step();
        err_clr_in = 1'b1;
        step();
        err_clr_in = 1'b0;
        check("rand_halt_clr", halted_out, 0);
      end
    end
    rand_ready = 0;
    drain();
    check("end_valid", out_valid_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
